// File: rtl/rc4_engine_if.sv
// Handshake and memory-port bundle for rc4_engine.
// master = the engine itself, slave = the key-search controller plus the S/ROM/RAM memories.
interface rc4_engine_if #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_AW    = 5
);
  localparam int KEY_W = 8 * KEY_BYTES;

  logic              start;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic              done;
  logic              fail;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] rom_addr;
  logic [7:0]        rom_rdata;
  logic [MSG_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_wren;

  modport master (
    input  start, key, s_rdata, rom_rdata,
    output busy, done, fail, s_addr, s_wdata, s_wren,
           rom_addr, ram_addr, ram_wdata, ram_wren
  );

  modport slave (
    output start, key, s_rdata, rom_rdata,
    input  busy, done, fail, s_addr, s_wdata, s_wren,
           rom_addr, ram_addr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/rc4_engine.sv
// Self-sequencing RC4 core: S-box init, KSA, PRGA and XOR decrypt of MSG_LEN ROM bytes into RAM.
// Define CHECK_ASCII_EN to abort on the first plaintext byte outside 'a'..'z' / space.
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic         clk,
  input  logic         reset,
  rc4_engine_if.master bus
);
  localparam int KEY_W = 8 * KEY_BYTES;
  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_RD_I, ST_WAIT_I, ST_RD_J, ST_WAIT_J,
    ST_WR_I, ST_WR_J, ST_RD_F, ST_WAIT_F, ST_DONE
  } state_t;

  state_t            state;
  logic [7:0]        i, j, si, sj;
  logic [MSG_AW-1:0] k;
  logic [KEY_W-1:0]  key_r;
  logic              prga;
  logic [7:0]        j_next;
  logic [7:0]        pt;
  logic              bad;

  // key_r is rotated one byte per KSA step, so its top byte is always key[i mod KEY_BYTES]
  always_comb begin
    j_next = j + bus.s_rdata + (prga ? 8'd0 : key_r[KEY_W-1 -: 8]);
    pt     = bus.s_rdata ^ bus.rom_rdata;
`ifdef CHECK_ASCII_EN
    bad    = !(((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20));
`else
    bad    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      si            <= '0;
      sj            <= '0;
      key_r         <= '0;
      prga          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.fail      <= 1'b0;
      bus.s_addr    <= '0;
      bus.s_wdata   <= '0;
      bus.s_wren    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_wren  <= 1'b0;
    end else begin
      bus.s_wren   <= 1'b0;
      bus.ram_wren <= 1'b0;
      bus.done     <= 1'b0;
      // Read addresses are set on the transition into RD_*, so data is valid during WAIT_*
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            key_r       <= bus.key;
            bus.fail    <= 1'b0;
            bus.busy    <= 1'b1;
            i           <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wren  <= 1'b1;
            state       <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (i == 8'd255) begin
            i          <= '0;
            j          <= '0;
            prga       <= 1'b0;
            bus.s_addr <= '0;
            state      <= ST_RD_I;
          end else begin
            i           <= i + 8'd1;
            bus.s_addr  <= i + 8'd1;
            bus.s_wdata <= i + 8'd1;
            bus.s_wren  <= 1'b1;
          end
        end
        ST_RD_I: state <= ST_WAIT_I;
        ST_WAIT_I: begin
          si         <= bus.s_rdata;
          j          <= j_next;
          bus.s_addr <= j_next;
          if (!prga) begin
            key_r <= (key_r << 8) | (key_r >> (KEY_W - 8));
          end
          state <= ST_RD_J;
        end
        ST_RD_J: state <= ST_WAIT_J;
        ST_WAIT_J: begin
          sj          <= bus.s_rdata;
          bus.s_addr  <= i;
          bus.s_wdata <= bus.s_rdata;
          bus.s_wren  <= 1'b1;
          state       <= ST_WR_I;
        end
        ST_WR_I: begin
          bus.s_addr  <= j;
          bus.s_wdata <= si;
          bus.s_wren  <= 1'b1;
          state       <= ST_WR_J;
        end
        // End of a swap: PRGA fetches the keystream byte, KSA advances i or enters PRGA at i=1
        ST_WR_J: begin
          if (prga) begin
            bus.s_addr   <= si + sj;
            bus.rom_addr <= k;
            state        <= ST_RD_F;
          end else if (i == 8'd255) begin
            i          <= 8'd1;
            j          <= '0;
            k          <= '0;
            prga       <= 1'b1;
            bus.s_addr <= 8'd1;
            state      <= ST_RD_I;
          end else begin
            i          <= i + 8'd1;
            bus.s_addr <= i + 8'd1;
            state      <= ST_RD_I;
          end
        end
        ST_RD_F: state <= ST_WAIT_F;
        ST_WAIT_F: begin
          bus.ram_wdata <= pt;
          bus.ram_addr  <= k;
          bus.ram_wren  <= 1'b1;
          if (bad || (k == K_LAST)) begin
            if (bad) begin
              bus.fail <= 1'b1;
            end
            bus.done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            k          <= k + 1'b1;
            i          <= i + 8'd1;
            bus.s_addr <= i + 8'd1;
            state      <= ST_RD_I;
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
